// File: rtl/mem_burst_ctrl.sv
// Burst controller between an upstream burst master and a MIG-style
// memory user interface. A single burst (read or write) is latched from
// the upstream request ports, split into one MIG command per beat, and
// completed with a one-cycle finish pulse.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// IDLE      | waiting for calibration and an upstream burst request
// MEM_WRITE | issuing write commands and streaming write beats
// WRITE_END | one-cycle wr_burst_finish pulse, back to IDLE
// MEM_READ  | issuing read commands and forwarding returned read data
// READ_END  | one-cycle rd_burst_finish pulse, back to IDLE
module mem_burst_ctrl #(
    parameter int MEM_DATA_BITS = 64,
    parameter int ADDR_BITS     = 24,
    parameter int APP_ADDR_BITS = 28
) (
    input  logic                     mem_clk,
    input  logic                     rst,

    input  logic                     rd_burst_req,
    input  logic                     wr_burst_req,
    input  logic [9:0]               rd_burst_len,
    input  logic [9:0]               wr_burst_len,
    input  logic [ADDR_BITS-1:0]     rd_burst_addr,
    input  logic [ADDR_BITS-1:0]     wr_burst_addr,

    output logic                     rd_burst_data_valid,
    output logic                     wr_burst_data_req,
    output logic [MEM_DATA_BITS-1:0] rd_burst_data,
    input  logic [MEM_DATA_BITS-1:0] wr_burst_data,
    output logic                     rd_burst_finish,
    output logic                     wr_burst_finish,

    input  logic                     init_calib_complete,
    output logic [APP_ADDR_BITS-1:0] app_addr,
    output logic [2:0]               app_cmd,
    output logic                     app_en,
    input  logic                     app_rdy,
    output logic [MEM_DATA_BITS-1:0] app_wdf_data,
    output logic                     app_wdf_wren,
    output logic                     app_wdf_end,
    input  logic                     app_wdf_rdy,
    input  logic [MEM_DATA_BITS-1:0] app_rd_data,
    input  logic                     app_rd_data_valid
);

    localparam logic [2:0] CMD_WR = 3'd0;
    localparam logic [2:0] CMD_RD = 3'd1;

    // Wide enough that the shift by 3 never loses bits before truncation.
    localparam int WIDE = APP_ADDR_BITS + ADDR_BITS + 3;

    typedef enum logic [2:0] {
        IDLE,
        MEM_WRITE,
        WRITE_END,
        MEM_READ,
        READ_END
    } state_t;

    state_t                 state;
    logic [9:0]             len_q;
    logic [ADDR_BITS-1:0]   addr_q;
    logic [9:0]             cmd_cnt;
    logic [9:0]             req_cnt;
    logic [9:0]             wdf_cnt;
    logic [9:0]             rd_cnt;

    logic                   cmd_acc;
    logic                   wdf_acc;
    logic [9:0]             cmd_cnt_nxt;
    logic [ADDR_BITS-1:0]   addr_nxt;

    // Beat address to MIG byte-lane address: the beat sum wraps in
    // ADDR_BITS, then the x8 scaling is truncated to APP_ADDR_BITS.
    function automatic logic [APP_ADDR_BITS-1:0] beat_to_app(input logic [ADDR_BITS-1:0] beat);
        logic [WIDE-1:0] w;
        w = {{(WIDE-ADDR_BITS){1'b0}}, beat} << 3;
        return w[APP_ADDR_BITS-1:0];
    endfunction

    assign cmd_acc     = app_en & app_rdy;
    assign wdf_acc     = app_wdf_wren & app_wdf_rdy;
    assign cmd_cnt_nxt = cmd_cnt + 10'd1;
    assign addr_nxt    = addr_q + ADDR_BITS'(cmd_cnt_nxt);

    // A new write beat is requested whenever the beat register is empty or
    // is being drained this cycle, so the pipe sustains one beat per cycle.
    assign wr_burst_data_req = (state == MEM_WRITE) && (req_cnt < len_q) &&
                               (!app_wdf_wren || app_wdf_rdy);

    // Upstream data arrives the cycle after a request and is held until the
    // next request, so it can be passed straight through to the MIG.
    assign app_wdf_data = wr_burst_data;
    assign app_wdf_end  = app_wdf_wren;

    // Burst sequencing FSM with all MIG/upstream outputs registered.
    always_ff @(posedge mem_clk) begin
        if (rst) begin
            state               <= IDLE;
            len_q               <= '0;
            addr_q              <= '0;
            cmd_cnt             <= '0;
            req_cnt             <= '0;
            wdf_cnt             <= '0;
            rd_cnt              <= '0;
            app_en              <= 1'b0;
            app_cmd             <= CMD_WR;
            app_addr            <= '0;
            app_wdf_wren        <= 1'b0;
            rd_burst_data_valid <= 1'b0;
            rd_burst_data       <= '0;
            rd_burst_finish     <= 1'b0;
            wr_burst_finish     <= 1'b0;
        end else begin
            wr_burst_finish     <= 1'b0;
            rd_burst_finish     <= 1'b0;
            rd_burst_data_valid <= 1'b0;

            case (state)
                IDLE: begin
                    app_en       <= 1'b0;
                    app_wdf_wren <= 1'b0;
                    if (init_calib_complete && rd_burst_req) begin
                        len_q    <= rd_burst_len;
                        addr_q   <= rd_burst_addr;
                        app_addr <= beat_to_app(rd_burst_addr);
                        app_cmd  <= CMD_RD;
                        cmd_cnt  <= '0;
                        req_cnt  <= '0;
                        wdf_cnt  <= '0;
                        rd_cnt   <= '0;
                        if (rd_burst_len == 10'd0) begin
                            state           <= READ_END;
                            rd_burst_finish <= 1'b1;
                        end else begin
                            state  <= MEM_READ;
                            app_en <= 1'b1;
                        end
                    end else if (init_calib_complete && wr_burst_req) begin
                        len_q    <= wr_burst_len;
                        addr_q   <= wr_burst_addr;
                        app_addr <= beat_to_app(wr_burst_addr);
                        app_cmd  <= CMD_WR;
                        cmd_cnt  <= '0;
                        req_cnt  <= '0;
                        wdf_cnt  <= '0;
                        rd_cnt   <= '0;
                        if (wr_burst_len == 10'd0) begin
                            state           <= WRITE_END;
                            wr_burst_finish <= 1'b1;
                        end else begin
                            state  <= MEM_WRITE;
                            app_en <= 1'b1;
                        end
                    end
                end

                MEM_WRITE: begin
                    if (cmd_acc) begin
                        cmd_cnt  <= cmd_cnt_nxt;
                        app_addr <= beat_to_app(addr_nxt);
                        app_en   <= (cmd_cnt_nxt < len_q);
                    end
                    if (wr_burst_data_req) begin
                        req_cnt      <= req_cnt + 10'd1;
                        app_wdf_wren <= 1'b1;
                    end else if (wdf_acc) begin
                        app_wdf_wren <= 1'b0;
                    end
                    if (wdf_acc) begin
                        wdf_cnt <= wdf_cnt + 10'd1;
                    end
                    if (cmd_cnt == len_q && wdf_cnt == len_q) begin
                        state           <= WRITE_END;
                        wr_burst_finish <= 1'b1;
                    end
                end

                WRITE_END: begin
                    state <= IDLE;
                end

                MEM_READ: begin
                    if (cmd_acc) begin
                        cmd_cnt  <= cmd_cnt_nxt;
                        app_addr <= beat_to_app(addr_nxt);
                        app_en   <= (cmd_cnt_nxt < len_q);
                    end
                    rd_burst_data_valid <= app_rd_data_valid;
                    if (app_rd_data_valid) begin
                        rd_burst_data <= app_rd_data;
                    end
                    // Finish follows the last forwarded beat by one cycle.
                    if (rd_burst_data_valid) begin
                        rd_cnt <= rd_cnt + 10'd1;
                        if (rd_cnt + 10'd1 == len_q) begin
                            state           <= READ_END;
                            rd_burst_finish <= 1'b1;
                        end
                    end
                end

                READ_END: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_burst_ctrl.sv
// Self-checking bench for mem_burst_ctrl: a MIG/upstream environment
// process records every command, write beat and read beat, and each test
// task compares those records against sequences derived from the burst
// rules with plain arithmetic.
`timescale 1ns/1ps
module tb_mem_burst_ctrl;

    localparam int DW  = 64;
    localparam int AW  = 24;
    localparam int PAW = 28;

    logic            mem_clk = 1'b0;
    logic            rst;
    logic            rd_burst_req;
    logic            wr_burst_req;
    logic [9:0]      rd_burst_len;
    logic [9:0]      wr_burst_len;
    logic [AW-1:0]   rd_burst_addr;
    logic [AW-1:0]   wr_burst_addr;
    logic            rd_burst_data_valid;
    logic            wr_burst_data_req;
    logic [DW-1:0]   rd_burst_data;
    logic [DW-1:0]   wr_burst_data;
    logic            rd_burst_finish;
    logic            wr_burst_finish;
    logic            init_calib_complete;
    logic [PAW-1:0]  app_addr;
    logic [2:0]      app_cmd;
    logic            app_en;
    logic            app_rdy;
    logic [DW-1:0]   app_wdf_data;
    logic            app_wdf_wren;
    logic            app_wdf_end;
    logic            app_wdf_rdy;
    logic [DW-1:0]   app_rd_data;
    logic            app_rd_data_valid;

    mem_burst_ctrl #(.MEM_DATA_BITS(DW), .ADDR_BITS(AW), .APP_ADDR_BITS(PAW)) dut (
        .mem_clk             (mem_clk),
        .rst                 (rst),
        .rd_burst_req        (rd_burst_req),
        .wr_burst_req        (wr_burst_req),
        .rd_burst_len        (rd_burst_len),
        .wr_burst_len        (wr_burst_len),
        .rd_burst_addr       (rd_burst_addr),
        .wr_burst_addr       (wr_burst_addr),
        .rd_burst_data_valid (rd_burst_data_valid),
        .wr_burst_data_req   (wr_burst_data_req),
        .rd_burst_data       (rd_burst_data),
        .wr_burst_data       (wr_burst_data),
        .rd_burst_finish     (rd_burst_finish),
        .wr_burst_finish     (wr_burst_finish),
        .init_calib_complete (init_calib_complete),
        .app_addr            (app_addr),
        .app_cmd             (app_cmd),
        .app_en              (app_en),
        .app_rdy             (app_rdy),
        .app_wdf_data        (app_wdf_data),
        .app_wdf_wren        (app_wdf_wren),
        .app_wdf_end         (app_wdf_end),
        .app_wdf_rdy         (app_wdf_rdy),
        .app_rd_data         (app_rd_data),
        .app_rd_data_valid   (app_rd_data_valid)
    );

    always #5 mem_clk = ~mem_clk;

    int cyc = 0;
    always @(posedge mem_clk) cyc = cyc + 1;

    int checks   = 0;
    int failures = 0;

    // main-owned controls
    int            clr_gen  = 0;
    int            rdy_mode = 0;
    logic [DW-1:0] wsrc [1024];

    // environment-owned records
    logic [30:0]   cmd_q [$];
    logic [DW-1:0] wdf_q [$];
    logic [DW-1:0] rd_q  [$];
    int            rd_pend [$];
    int            last_sched, clr_seen, widx, tsched;
    int            wfin_cnt, rfin_cnt, wfin_cyc, rfin_cyc, last_rdv_cyc;
    int            first_wdf_cyc, last_wdf_cyc, wreq_cnt, stab_err, end_err;
    logic          wreq_prev, prev_stall;
    logic [2:0]    prev_cmd;
    logic [PAW-1:0] prev_addr;
    logic [DW-1:0] ret_idx;

    // Expected MIG address of beat k of a burst starting at beat address base.
    function automatic logic [PAW-1:0] exp_app_addr(input longint base, input int k);
        longint unsigned beat;
        beat = longint'(base + longint'(k)) % (64'd1 << AW);
        return PAW'((beat * 64'd8) % (64'd1 << PAW));
    endfunction

    // MIG + upstream environment: record at negedge, drive at posedge+1.
    initial begin : env
        app_rdy = 1'b1; app_wdf_rdy = 1'b1; app_rd_data = '0; app_rd_data_valid = 1'b0;
        wr_burst_data = '0; clr_seen = -1;
        forever begin
            @(negedge mem_clk);
            if (clr_seen != clr_gen) begin
                cmd_q.delete(); wdf_q.delete(); rd_q.delete(); rd_pend.delete();
                last_sched = 0; widx = 0; ret_idx = '0;
                wfin_cnt = 0; rfin_cnt = 0; wfin_cyc = -1; rfin_cyc = -1; last_rdv_cyc = -1;
                first_wdf_cyc = -1; last_wdf_cyc = -1; wreq_cnt = 0; stab_err = 0; end_err = 0;
                wreq_prev = 1'b0; prev_stall = 1'b0; prev_cmd = '0; prev_addr = '0;
                clr_seen = clr_gen;
            end
            if (prev_stall && (!app_en || app_cmd !== prev_cmd || app_addr !== prev_addr))
                stab_err++;
            prev_stall = app_en && !app_rdy;
            prev_cmd   = app_cmd;
            prev_addr  = app_addr;
            if (app_en && app_rdy) begin
                cmd_q.push_back({app_cmd, app_addr});
                if (app_cmd == 3'd1) begin
                    tsched = cyc + int'($urandom_range(1, 4));
                    if (tsched <= last_sched) tsched = last_sched + 1;
                    last_sched = tsched;
                    rd_pend.push_back(tsched);
                end
            end
            if (app_wdf_end !== app_wdf_wren) end_err++;
            if (app_wdf_wren && app_wdf_rdy) begin
                if (wdf_q.size() == 0) first_wdf_cyc = cyc;
                last_wdf_cyc = cyc;
                wdf_q.push_back(app_wdf_data);
            end
            if (rd_burst_data_valid) begin
                rd_q.push_back(rd_burst_data);
                last_rdv_cyc = cyc;
            end
            if (wr_burst_finish) begin wfin_cnt++; wfin_cyc = cyc; end
            if (rd_burst_finish) begin rfin_cnt++; rfin_cyc = cyc; end
            wreq_prev = wr_burst_data_req;
            if (wr_burst_data_req) wreq_cnt++;

            @(posedge mem_clk);
            #1;
            app_rd_data_valid = 1'b0;
            if (rd_pend.size() > 0 && rd_pend[0] <= cyc) begin
                void'(rd_pend.pop_front());
                app_rd_data_valid = 1'b1;
                app_rd_data = ret_idx;
                ret_idx = ret_idx + 1;
            end
            if (wreq_prev && widx < 1024) begin
                wr_burst_data = wsrc[widx];
                widx++;
            end
            app_rdy     = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
            app_wdf_rdy = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic clr_env(input int mode);
        rdy_mode = mode;
        for (int i = 0; i < 1024; i++) wsrc[i] = {$urandom, $urandom};
        clr_gen++;
        @(negedge mem_clk);
        #2;
    endtask

    // Present a request for one cycle, then scramble the request lines.
    task automatic issue(input bit is_rd, input int len, input logic [AW-1:0] addr, output int req_cyc);
        @(posedge mem_clk);
        #1;
        if (is_rd) begin
            rd_burst_req = 1'b1; rd_burst_len = 10'(len); rd_burst_addr = addr;
        end else begin
            wr_burst_req = 1'b1; wr_burst_len = 10'(len); wr_burst_addr = addr;
        end
        req_cyc = cyc;
        @(posedge mem_clk);
        #1;
        rd_burst_req = 1'b0; wr_burst_req = 1'b0;
        rd_burst_len = 10'($urandom); wr_burst_len = 10'($urandom);
        rd_burst_addr = AW'($urandom); wr_burst_addr = AW'($urandom);
    endtask

    task automatic wait_fin(input bit is_rd, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge mem_clk);
            #2;
            if ((is_rd ? rfin_cnt : wfin_cnt) > 0) begin ok = 1'b1; break; end
        end
        repeat (3) @(negedge mem_clk);
        #2;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge mem_clk);
        #2;
        checks++;
        if ({app_en, app_wdf_wren, rd_burst_data_valid, rd_burst_finish, wr_burst_finish, wr_burst_data_req} !== 6'b0) begin
            failures++;
            $display("FAIL reset_ctrl: got en=%b wren=%b rdv=%b rfin=%b wfin=%b wreq=%b, want all 0",
                     app_en, app_wdf_wren, rd_burst_data_valid, rd_burst_finish, wr_burst_finish, wr_burst_data_req);
        end
        checks++;
        if (app_addr !== '0 || app_cmd !== 3'd0 || rd_burst_data !== '0) begin
            failures++;
            $display("FAIL reset_vals: got addr=%h cmd=%0d rdata=%h, want 0/0/0", app_addr, app_cmd, rd_burst_data);
        end
        @(posedge mem_clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic test_calib_gate();
        clr_env(0);
        init_calib_complete = 1'b0;
        @(posedge mem_clk);
        #1;
        wr_burst_req = 1'b1; wr_burst_len = 10'd4; wr_burst_addr = 24'h10;
        repeat (6) @(posedge mem_clk);
        #1;
        wr_burst_req = 1'b0;
        repeat (3) @(negedge mem_clk);
        #2;
        checks++;
        if (cmd_q.size() != 0 || wfin_cnt != 0 || wreq_cnt != 0) begin
            failures++;
            $display("FAIL calib_gate: got cmds=%0d fin=%0d dreq=%0d, want 0/0/0", cmd_q.size(), wfin_cnt, wreq_cnt);
        end
        init_calib_complete = 1'b1;
    endtask

    task automatic test_write_128();
        int rc, bad; bit ok;
        clr_env(0);
        issue(1'b0, 128, 24'd0, rc);
        wait_fin(1'b0, 400, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL wr128_timeout: no wr_burst_finish, want one"); end
        bad = -1;
        foreach (cmd_q[i]) if (bad < 0 && cmd_q[i] !== {3'd0, exp_app_addr(0, i)}) bad = i;
        checks++;
        if (cmd_q.size() != 128 || bad >= 0) begin
            failures++;
            $display("FAIL wr128_cmds: got %0d cmds first bad %0d, want 128 write cmds at 0,8,..", cmd_q.size(), bad);
        end
        bad = -1;
        foreach (wdf_q[i]) if (bad < 0 && wdf_q[i] !== wsrc[i]) bad = i;
        checks++;
        if (wdf_q.size() != 128 || bad >= 0 || wreq_cnt != 128) begin
            failures++;
            $display("FAIL wr128_data: got %0d beats %0d reqs first bad %0d, want 128/128", wdf_q.size(), wreq_cnt, bad);
        end
        checks++;
        if (wfin_cnt != 1 || last_wdf_cyc - first_wdf_cyc != 127 || end_err != 0) begin
            failures++;
            $display("FAIL wr128_fin: got fin=%0d span=%0d end_err=%0d, want 1/127/0",
                     wfin_cnt, last_wdf_cyc - first_wdf_cyc, end_err);
        end
    endtask

    task automatic test_read_128();
        int rc, bad; bit ok;
        clr_env(0);
        issue(1'b1, 128, 24'd128, rc);
        wait_fin(1'b1, 400, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL rd128_timeout: no rd_burst_finish, want one"); end
        bad = -1;
        foreach (cmd_q[i]) if (bad < 0 && cmd_q[i] !== {3'd1, exp_app_addr(128, i)}) bad = i;
        checks++;
        if (cmd_q.size() != 128 || bad >= 0) begin
            failures++;
            $display("FAIL rd128_cmds: got %0d cmds first bad %0d, want 128 read cmds from 1024", cmd_q.size(), bad);
        end
        bad = -1;
        foreach (rd_q[i]) if (bad < 0 && rd_q[i] !== DW'(i)) bad = i;
        checks++;
        if (rd_q.size() != 128 || bad >= 0) begin
            failures++;
            $display("FAIL rd128_data: got %0d beats first bad %0d, want 0..127", rd_q.size(), bad);
        end
        checks++;
        if (rfin_cnt != 1 || rfin_cyc != last_rdv_cyc + 1 || wreq_cnt != 0 || wfin_cnt != 0) begin
            failures++;
            $display("FAIL rd128_fin: got fin=%0d at %0d last valid %0d dreq=%0d, want 1 at last+1, 0 dreq",
                     rfin_cnt, rfin_cyc, last_rdv_cyc, wreq_cnt);
        end
    endtask

    task automatic test_write_random_rdy();
        int rc, bad; bit ok; logic [AW-1:0] a;
        clr_env(1);
        a = AW'($urandom);
        issue(1'b0, 16, a, rc);
        wait_fin(1'b0, 500, ok);
        checks++;
        if (!ok) begin failures++; $display("FAIL wrrnd_timeout: no wr_burst_finish, want one"); end
        bad = -1;
        foreach (cmd_q[i]) if (bad < 0 && cmd_q[i] !== {3'd0, exp_app_addr(longint'(a), i)}) bad = i;
        checks++;
        if (cmd_q.size() != 16 || bad >= 0 || stab_err != 0) begin
            failures++;
            $display("FAIL wrrnd_cmds: got %0d cmds first bad %0d stall_err %0d, want 16/-1/0", cmd_q.size(), bad, stab_err);
        end
        bad = -1;
        foreach (wdf_q[i]) if (bad < 0 && wdf_q[i] !== wsrc[i]) bad = i;
        checks++;
        if (wdf_q.size() != 16 || bad >= 0 || wfin_cnt != 1) begin
            failures++;
            $display("FAIL wrrnd_data: got %0d beats first bad %0d fin %0d, want 16/-1/1", wdf_q.size(), bad, wfin_cnt);
        end
    endtask

    task automatic test_priority();
        int bad; bit ok;
        clr_env(0);
        @(posedge mem_clk);
        #1;
        rd_burst_req = 1'b1; rd_burst_len = 10'd5; rd_burst_addr = 24'h000300;
        wr_burst_req = 1'b1; wr_burst_len = 10'd7; wr_burst_addr = 24'h000900;
        @(posedge mem_clk);
        #1;
        rd_burst_req = 1'b0; wr_burst_req = 1'b0;
        wait_fin(1'b1, 100, ok);
        bad = -1;
        foreach (cmd_q[i]) if (bad < 0 && cmd_q[i] !== {3'd1, exp_app_addr(24'h300, i)}) bad = i;
        checks++;
        if (!ok || cmd_q.size() != 5 || bad >= 0 || wfin_cnt != 0 || wreq_cnt != 0) begin
            failures++;
            $display("FAIL priority: got rfin=%0b cmds=%0d bad=%0d wfin=%0d dreq=%0d, want read of 5 only",
                     ok, cmd_q.size(), bad, wfin_cnt, wreq_cnt);
        end
    endtask

    task automatic test_len_zero();
        int rc;
        for (int k = 0; k < 2; k++) begin
            clr_env(0);
            @(posedge mem_clk);
            #1;
            if (k == 0) begin wr_burst_req = 1'b1; wr_burst_len = 10'd0; wr_burst_addr = 24'h55; end
            else        begin rd_burst_req = 1'b1; rd_burst_len = 10'd0; rd_burst_addr = 24'h66; end
            rc = cyc;
            // still high during the finish cycle: must not restart
            @(posedge mem_clk);
            #1;
            @(posedge mem_clk);
            #1;
            wr_burst_req = 1'b0; rd_burst_req = 1'b0;
            repeat (5) @(negedge mem_clk);
            #2;
            checks++;
            if (k == 0 && (wfin_cnt != 1 || wfin_cyc != rc + 1 || rfin_cnt != 0)) begin
                failures++;
                $display("FAIL len0_wr_fin: got %0d pulses at %0d, want 1 at %0d", wfin_cnt, wfin_cyc, rc + 1);
            end
            if (k == 1 && (rfin_cnt != 1 || rfin_cyc != rc + 1 || wfin_cnt != 0)) begin
                failures++;
                $display("FAIL len0_rd_fin: got %0d pulses at %0d, want 1 at %0d", rfin_cnt, rfin_cyc, rc + 1);
            end
            checks++;
            if (cmd_q.size() != 0 || wdf_q.size() != 0 || wreq_cnt != 0) begin
                failures++;
                $display("FAIL len0_traffic: got cmds=%0d beats=%0d dreq=%0d, want 0/0/0",
                         cmd_q.size(), wdf_q.size(), wreq_cnt);
            end
        end
    endtask

    task automatic test_reset_mid_read();
        int rc, n_rd, n_cmd; bit ok;
        clr_env(0);
        issue(1'b1, 300, 24'h001000, rc);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge mem_clk);
            #2;
            if (rd_q.size() >= 40) begin ok = 1'b1; break; end
        end
        checks++;
        if (!ok) begin failures++; $display("FAIL rstmid_timeout: got %0d beats, want 40", rd_q.size()); end
        @(posedge mem_clk);
        #1;
        rst = 1'b1;
        @(posedge mem_clk);
        #1;
        rst = 1'b0;
        @(negedge mem_clk);
        #2;
        checks++;
        if ({app_en, app_wdf_wren, rd_burst_data_valid, rd_burst_finish, wr_burst_finish, wr_burst_data_req} !== 6'b0 ||
            app_cmd !== 3'd0 || app_addr !== '0 || rd_burst_data !== '0) begin
            failures++;
            $display("FAIL rstmid_outputs: got en=%b rdv=%b cmd=%0d addr=%h rdata=%h, want reset values",
                     app_en, rd_burst_data_valid, app_cmd, app_addr, rd_burst_data);
        end
        n_rd = rd_q.size();
        n_cmd = cmd_q.size();
        repeat (8) @(negedge mem_clk);
        #2;
        checks++;
        if (rd_q.size() != n_rd || cmd_q.size() != n_cmd || rfin_cnt != 0) begin
            failures++;
            $display("FAIL rstmid_late: got beats %0d->%0d cmds %0d->%0d fin %0d, want no change, fin 0",
                     n_rd, rd_q.size(), n_cmd, cmd_q.size(), rfin_cnt);
        end
    endtask

    task automatic test_addr_wrap();
        int rc; bit ok;
        clr_env(0);
        issue(1'b0, 2, 24'hFFFFFF, rc);
        wait_fin(1'b0, 100, ok);
        checks++;
        if (!ok || cmd_q.size() != 2 || wdf_q.size() != 2) begin
            failures++;
            $display("FAIL wrap_count: got fin=%0b cmds=%0d beats=%0d, want 1/2/2", ok, cmd_q.size(), wdf_q.size());
        end else begin
            checks++;
            if (cmd_q[0][PAW-1:0] !== exp_app_addr(24'hFFFFFF, 0) || cmd_q[1][PAW-1:0] !== '0) begin
                failures++;
                $display("FAIL wrap_addr: got %h,%h want %h,0", cmd_q[0][PAW-1:0], cmd_q[1][PAW-1:0],
                         exp_app_addr(24'hFFFFFF, 0));
            end
        end
    endtask

    task automatic test_random_bursts();
        int rc, bad, len; bit ok, is_rd; logic [AW-1:0] a;
        for (int n = 0; n < 8; n++) begin
            clr_env(1);
            is_rd = 1'($urandom_range(0, 1));
            len   = int'($urandom_range(0, 24));
            a     = (n % 3 == 0) ? AW'(24'hFFFFFF - $urandom_range(0, 8)) : AW'($urandom);
            issue(is_rd, len, a, rc);
            wait_fin(is_rd, 800, ok);
            bad = -1;
            foreach (cmd_q[i]) if (bad < 0 && cmd_q[i] !== {(is_rd ? 3'd1 : 3'd0), exp_app_addr(longint'(a), i)}) bad = i;
            checks++;
            if (!ok || cmd_q.size() != len || bad >= 0 || stab_err != 0) begin
                failures++;
                $display("FAIL rnd_cmds[%0d]: rd=%0b len=%0d got fin=%0b cmds=%0d bad=%0d stall_err=%0d",
                         n, is_rd, len, ok, cmd_q.size(), bad, stab_err);
            end
            bad = -1;
            if (is_rd) begin
                foreach (rd_q[i]) if (bad < 0 && rd_q[i] !== DW'(i)) bad = i;
            end else begin
                foreach (wdf_q[i]) if (bad < 0 && wdf_q[i] !== wsrc[i]) bad = i;
            end
            checks++;
            if ((is_rd ? rd_q.size() : wdf_q.size()) != len || bad >= 0 ||
                (is_rd ? wdf_q.size() : rd_q.size()) != 0 ||
                (is_rd ? rfin_cnt : wfin_cnt) != 1 || (is_rd ? wfin_cnt : rfin_cnt) != 0) begin
                failures++;
                $display("FAIL rnd_data[%0d]: rd=%0b len=%0d got rbeats=%0d wbeats=%0d bad=%0d rfin=%0d wfin=%0d",
                         n, is_rd, len, rd_q.size(), wdf_q.size(), bad, rfin_cnt, wfin_cnt);
            end
        end
    endtask

    initial begin : watchdog
        #5ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        rst = 1'b1; init_calib_complete = 1'b0;
        rd_burst_req = 1'b0; wr_burst_req = 1'b0;
        rd_burst_len = '0; wr_burst_len = '0; rd_burst_addr = '0; wr_burst_addr = '0;
        test_reset();
        test_calib_gate();
        test_write_128();
        test_read_128();
        test_write_random_rdy();
        test_priority();
        test_len_zero();
        test_reset_mid_read();
        test_addr_wrap();
        test_random_bursts();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
